// File: rtl/pll_seq_pkg.sv
// Shared state encoding and reset constants for the PLL lock sequencer.
// The encodings are visible to software through o_state, so they must not change.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5,
      ST_BYPASS    = 3'd6
   } pll_seq_state_t;

   localparam logic [7:0] DIVMUL_RST = 8'd1;

   // PLL may only be released from reset while a lock is being acquired or held.
   function automatic logic pll_released(input pll_seq_state_t s);
      return (s == ST_WAIT_LOCK) || (s == ST_STABLE) || (s == ST_RUN);
   endfunction

   function automatic logic seq_busy(input pll_seq_state_t s);
      return (s == ST_RESET) || (s == ST_WAIT_LOCK) || (s == ST_STABLE);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for quasi-static asynchronous inputs.
// Each bit is synchronised independently, so it must not carry multi-bit values.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up/reconfiguration sequencer: reset, lock wait with timeout, lock debounce,
// then hands the SoC clock mux over to the PLL; falls back to xo_clk on any disturbance.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RESET_CYCLES  = 16,
   parameter int unsigned STABLE_CYCLES = 8,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             xo_clk,
   input  logic             reset_n,
   input  logic             i_pll_enable,
   input  logic             i_pll_bypass,
   input  logic             i_cfg_update,
   input  logic [7:0]       i_pll_div,
   input  logic [7:0]       i_pll_mul,
   input  logic [CNT_W-1:0] i_lock_timeout,
   input  logic             i_pll_locked,
   input  logic             i_pll_error,
   output logic             o_pll_reset,
   output logic [7:0]       o_pll_div,
   output logic [7:0]       o_pll_mul,
   output logic             o_soc_clk_select,
   output logic             o_busy,
   output logic             o_timeout_err,
   output logic [2:0]       o_state
);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             lock_s;
   logic             err_s;
   pll_seq_state_t   state;
   pll_seq_state_t   state_next;
   logic [CNT_W-1:0] cnt;
   logic             restart;
   logic             timed_out;

   sync_2ff #(.WIDTH(2)) u_sync (
      .clk   (xo_clk),
      .rst_n (reset_n),
      .d     ({i_pll_error, i_pll_locked}),
      .q     (sync_q)
   );

   assign lock_s  = sync_q[0];
   assign err_s   = sync_q[1];
   assign o_state = state;

   always_comb begin
      state_next = state;
      timed_out  = (i_lock_timeout != '0) && (cnt >= (i_lock_timeout - CNT_ONE));
      if (!i_pll_enable) begin
         state_next = ST_OFF;
      end else if (i_pll_bypass) begin
         state_next = ST_BYPASS;
      end else begin
         case (state)
            ST_OFF, ST_BYPASS: state_next = ST_RESET;
            ST_FAIL: begin
               if (!err_s && i_cfg_update) state_next = ST_RESET;
            end
            ST_RESET, ST_WAIT_LOCK, ST_STABLE, ST_RUN: begin
               if (err_s) begin
                  state_next = ST_FAIL;
               end else if (i_cfg_update) begin
                  state_next = ST_RESET;
               end else begin
                  case (state)
                     ST_RESET: if (cnt >= RESET_LAST) state_next = ST_WAIT_LOCK;
                     // Lock is checked first so a same-cycle lock beats the timeout.
                     ST_WAIT_LOCK: begin
                        if (lock_s)         state_next = ST_STABLE;
                        else if (timed_out) state_next = ST_FAIL;
                     end
                     ST_STABLE: begin
                        if (!lock_s)                state_next = ST_WAIT_LOCK;
                        else if (cnt >= STABLE_LAST) state_next = ST_RUN;
                     end
                     default: if (!lock_s) state_next = ST_WAIT_LOCK;
                  endcase
               end
            end
            default: state_next = ST_OFF;
         endcase
      end
   end

   // Re-entering RESET through cfg_update counts as a fresh entry.
   assign restart = (state_next == ST_RESET) && ((state != ST_RESET) || i_cfg_update);

   // Shared phase counter. STABLE is entered on a locked cycle, so it starts at one.
   always_ff @(posedge xo_clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (restart || (state_next != state)) begin
         cnt <= (state_next == ST_STABLE) ? CNT_ONE : '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   always_ff @(posedge xo_clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_OFF;
         o_pll_reset      <= 1'b1;
         o_pll_div        <= DIVMUL_RST;
         o_pll_mul        <= DIVMUL_RST;
         o_soc_clk_select <= 1'b0;
         o_busy           <= 1'b0;
         o_timeout_err    <= 1'b0;
      end else begin
         state            <= state_next;
         o_pll_reset      <= !pll_released(state_next);
         o_busy           <= seq_busy(state_next);
         o_soc_clk_select <= (state == ST_RUN);
         if (restart) begin
            o_pll_div <= i_pll_div;
            o_pll_mul <= i_pll_mul;
         end
         if (state_next == ST_OFF) begin
            o_timeout_err <= 1'b0;
         end else if ((state_next == ST_FAIL) && (state != ST_FAIL)) begin
            o_timeout_err <= 1'b1;
         end else if ((state == ST_FAIL) && (state_next == ST_RESET)) begin
            o_timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: bring-up, timeout, lock glitch, reconfig,
// error/update priority, bypass, disable and asynchronous reset.
module tb_pll_lock_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        en = 1'b0;
   logic        byp = 1'b0;
   logic        cfg = 1'b0;
   logic [7:0]  div = 8'd4;
   logic [7:0]  mul = 8'd20;
   logic [31:0] tmo = 32'd0;
   logic        locked = 1'b0;
   logic        err = 1'b0;

   logic        pll_reset;
   logic [7:0]  pdiv;
   logic [7:0]  pmul;
   logic        sel;
   logic        busy;
   logic        terr;
   logic [2:0]  st;

   int checks = 0;
   int errors = 0;

   pll_lock_sequencer dut (
      .xo_clk           (clk),
      .reset_n          (reset_n),
      .i_pll_enable     (en),
      .i_pll_bypass     (byp),
      .i_cfg_update     (cfg),
      .i_pll_div        (div),
      .i_pll_mul        (mul),
      .i_lock_timeout   (tmo),
      .i_pll_locked     (locked),
      .i_pll_error      (err),
      .o_pll_reset      (pll_reset),
      .o_pll_div        (pdiv),
      .o_pll_mul        (pmul),
      .o_soc_clk_select (sel),
      .o_busy           (busy),
      .o_timeout_err    (terr),
      .o_state          (st)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      tick(3);
      checks += 6;
      if (st !== 3'd0)       begin errors++; $display("FAIL reset_state: got %0d want 0", st); end
      if (pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pll_reset: got %b want 1", pll_reset); end
      if ({pdiv, pmul} !== 16'h0101) begin errors++; $display("FAIL reset_divmul: got %0d/%0d want 1/1", pdiv, pmul); end
      if (sel !== 1'b0)      begin errors++; $display("FAIL reset_select: got %b want 0", sel); end
      if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (terr !== 1'b0)     begin errors++; $display("FAIL reset_terr: got %b want 0", terr); end
      reset_n = 1'b1;
      tick(2);
      checks++;
      if (st !== 3'd0) begin errors++; $display("FAIL reset_idle_off: got %0d want 0", st); end
      $display("test_reset done");
   endtask

   task automatic test_bringup();
      int n;
      en = 1'b1;
      tick(1);
      div = 8'd9;
      checks += 3;
      if (st !== 3'd1) begin errors++; $display("FAIL bringup_state: got %0d want 1", st); end
      if (pdiv !== 8'd4 || pmul !== 8'd20) begin errors++; $display("FAIL bringup_divmul: got %0d/%0d want 4/20", pdiv, pmul); end
      if (busy !== 1'b1) begin errors++; $display("FAIL bringup_busy: got %b want 1", busy); end
      n = 1;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (!pll_reset) break;
         n++;
      end
      checks += 2;
      if (n != 16) begin errors++; $display("FAIL bringup_reset_len: got %0d want 16", n); end
      if (st !== 3'd2) begin errors++; $display("FAIL bringup_wait: got %0d want 2", st); end
      tick(5);
      locked = 1'b1;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         n++;
         if (sel) break;
      end
      checks += 2;
      if (n != 11 || sel !== 1'b1) begin errors++; $display("FAIL bringup_select_latency: got %0d cycles sel=%b want 11 sel=1", n, sel); end
      if (pdiv !== 8'd4 || pmul !== 8'd20 || pll_reset !== 1'b0) begin errors++; $display("FAIL bringup_hold: got %0d/%0d rst=%b want 4/20 rst=0", pdiv, pmul, pll_reset); end
      div = 8'd4;
      $display("test_bringup done: select after %0d cycles", n);
   endtask

   task automatic test_lock_glitch();
      int n;
      locked = 1'b0;
      tick(3);
      checks++;
      if (st !== 3'd2) begin errors++; $display("FAIL glitch_run_loss: got %0d want 2", st); end
      tick(1);
      checks++;
      if (sel !== 1'b0) begin errors++; $display("FAIL glitch_select_drop: got %b want 0", sel); end
      locked = 1'b1;
      tick(6);
      checks++;
      if (st !== 3'd3) begin errors++; $display("FAIL glitch_stable: got %0d want 3", st); end
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      tick(2);
      checks++;
      if (st !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL glitch_back_to_wait: got st=%0d busy=%b want 2/1", st, busy); end
      n = 2;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         n++;
         if (sel) break;
      end
      checks++;
      if (n != 11 || sel !== 1'b1) begin errors++; $display("FAIL glitch_fresh_count: got %0d sel=%b want 11 sel=1", n, sel); end
      $display("test_lock_glitch done: reselect after %0d cycles", n);
   endtask

   task automatic test_reconfig();
      int n;
      div = 8'd2;
      mul = 8'd10;
      cfg = 1'b1;
      tick(1);
      cfg = 1'b0;
      checks++;
      if (st !== 3'd1 || pdiv !== 8'd2 || pmul !== 8'd10 || pll_reset !== 1'b1) begin
         errors++; $display("FAIL reconfig_entry: got st=%0d %0d/%0d rst=%b want 1 2/10 1", st, pdiv, pmul, pll_reset);
      end
      tick(1);
      checks++;
      if (sel !== 1'b0) begin errors++; $display("FAIL reconfig_select: got %b want 0", sel); end
      n = 2;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (!pll_reset) break;
         n++;
      end
      checks++;
      if (n != 16) begin errors++; $display("FAIL reconfig_reset_len: got %0d want 16", n); end
      n = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         n++;
         if (sel) break;
      end
      checks++;
      if (n != 9 || sel !== 1'b1) begin errors++; $display("FAIL reconfig_relock: got %0d sel=%b want 9 sel=1", n, sel); end
      $display("test_reconfig done");
   endtask

   task automatic test_timeout();
      tmo = 32'd100;
      locked = 1'b0;
      tick(3);
      checks++;
      if (st !== 3'd2) begin errors++; $display("FAIL timeout_enter_wait: got %0d want 2", st); end
      tick(99);
      checks++;
      if (st !== 3'd2 || terr !== 1'b0) begin errors++; $display("FAIL timeout_early: got st=%0d terr=%b want 2/0", st, terr); end
      tick(1);
      checks++;
      if (st !== 3'd5 || terr !== 1'b1 || pll_reset !== 1'b1 || sel !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL timeout_fire: got st=%0d terr=%b rst=%b sel=%b busy=%b want 5/1/1/0/0", st, terr, pll_reset, sel, busy);
      end
      tmo = 32'd0;
      cfg = 1'b1;
      tick(1);
      cfg = 1'b0;
      checks++;
      if (st !== 3'd1 || terr !== 1'b0) begin errors++; $display("FAIL timeout_recover: got st=%0d terr=%b want 1/0", st, terr); end
      $display("test_timeout done");
   endtask

   task automatic test_priority();
      locked = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (sel) break;
      end
      checks++;
      if (sel !== 1'b1) begin errors++; $display("FAIL prio_run: got sel=%b want 1", sel); end
      err = 1'b1;
      tick(2);
      div = 8'd7;
      mul = 8'd7;
      cfg = 1'b1;
      tick(1);
      cfg = 1'b0;
      checks++;
      if (st !== 3'd5 || terr !== 1'b1 || pdiv !== 8'd2) begin
         errors++; $display("FAIL prio_err_wins: got st=%0d terr=%b div=%0d want 5/1/2", st, terr, pdiv);
      end
      err = 1'b0;
      tick(2);
      cfg = 1'b1;
      tick(1);
      cfg = 1'b0;
      checks++;
      if (st !== 3'd1 || terr !== 1'b0 || pdiv !== 8'd7 || pmul !== 8'd7) begin
         errors++; $display("FAIL prio_cfg_clear: got st=%0d terr=%b %0d/%0d want 1/0 7/7", st, terr, pdiv, pmul);
      end
      $display("test_priority done");
   endtask

   task automatic test_bypass_disable();
      locked = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (!pll_reset) break;
      end
      checks++;
      if (st !== 3'd2) begin errors++; $display("FAIL bypass_pre_wait: got %0d want 2", st); end
      byp = 1'b1;
      tick(1);
      checks++;
      if (st !== 3'd6 || sel !== 1'b0 || pll_reset !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL bypass_enter: got st=%0d sel=%b rst=%b busy=%b want 6/0/1/0", st, sel, pll_reset, busy);
      end
      en = 1'b0;
      tick(1);
      checks++;
      if (st !== 3'd0 || terr !== 1'b0 || pdiv !== 8'd7) begin errors++; $display("FAIL disable_off: got st=%0d terr=%b div=%0d want 0/0/7", st, terr, pdiv); end
      div = 8'd3;
      cfg = 1'b1;
      tick(1);
      cfg = 1'b0;
      checks++;
      if (st !== 3'd0 || pdiv !== 8'd7) begin errors++; $display("FAIL off_cfg_ignored: got st=%0d div=%0d want 0/7", st, pdiv); end
      byp = 1'b0;
      en = 1'b1;
      locked = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (sel) break;
      end
      checks++;
      if (sel !== 1'b1 || pdiv !== 8'd3) begin errors++; $display("FAIL rerun: got sel=%b div=%0d want 1/3", sel, pdiv); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (st !== 3'd0 || pll_reset !== 1'b1 || pdiv !== 8'd1 || pmul !== 8'd1 || sel !== 1'b0 || busy !== 1'b0 || terr !== 1'b0) begin
         errors++; $display("FAIL async_reset: got st=%0d rst=%b %0d/%0d sel=%b busy=%b terr=%b want 0 1 1/1 0 0 0", st, pll_reset, pdiv, pmul, sel, busy, terr);
      end
      tick(1);
      reset_n = 1'b1;
      $display("test_bypass_disable done");
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_lock_glitch();
      test_reconfig();
      test_timeout();
      test_priority();
      test_bypass_disable();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
